seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Passive monitor for the multiplexed 8-digit seven-segment bus (active-low segments G..A, active-low one-hot digit commons). It samples the scanned segment and common lines, rejects transitional "ghost" patterns and decodes each settled digit back to a nibble. It then reassembles a full 8-digit scan into a 32-bit word. It sits beside the display driver as the receive end of the same bus, for self-check on the board and for the simulation scoreboard.

## Interface
- SETTLE_CYCLES, 16: consecutive identical samples required before a digit is captured; legal range 2..65535.
- TIMEOUT_CYCLES, 20000: maximum cycles between captures while assembling a frame; legal range > SETTLE_CYCLES.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- seg_n  in  7  segment lines, bit order {G,F,E,D,C,B,A}, 0 = lit.
- com_n  in  8  digit commons, 0 = selected; com_n[i] selects digit i, which is value[4i+3:4i].
- value  out  32  last completely assembled word; reset 0.
- value_valid  out  1  one-cycle pulse when value updates; reset 0.
- pattern_err  out  1  qualified by value_valid: some digit in this frame had an undecodable pattern; reset 0.
- frame_err  out  1  one-cycle pulse on out-of-order digit or timeout during assembly; reset 0.

## Operation
- Inputs are registered once. All logic acts on the registered sample {seg_n, com_n}.
- Settle counter:
  - Cleared when the sample differs from the previous sample.
  - Otherwise increments, saturating.
  - A capture fires once, when the count reaches SETTLE_CYCLES-1. The capture is not re-armed until the sample changes.
- A capture is ignored when com_n is not exactly one-hot-low, for example all-high blanking or multiple digits selected.
- Decode: the 16 standard patterns map to 0..F (0 = 1000000, 9 = 0010000, A = 0001000, F = 0001110).
  - Any other pattern yields nibble 0 and sets the frame's pattern error flag.
- FSM HUNT:
  - Waits for a capture of digit 0, then stores its nibble.
  - Sets expect=1, clears the frame pattern flag to that digit's result, and goes to ASSEMBLE.
  - Captures of other digits are ignored silently.
- FSM ASSEMBLE, on a capture of digit == expect:
  - Store the nibble and OR in the pattern flag.
  - If expect==7: load value from the assembled word, pulse value_valid, drive pattern_err, and go to HUNT.
  - Otherwise expect++.
- FSM ASSEMBLE, on a capture of digit != expect: pulse frame_err.
  - If the digit is 0, restart assembly with it (expect=1).
  - Else go to HUNT.
- FSM ASSEMBLE, timeout: TIMEOUT_CYCLES cycles with no capture causes a frame_err pulse and a return to HUNT.
- Partial frames never modify value.
- Back-to-back frames are supported: digit 7 followed by digit 0 yields a valid pulse every scan.

## Timing
- An input stable from edge k is captured at edge k+SETTLE_CYCLES, counting 1 input register + SETTLE_CYCLES-1.
- value, value_valid and pattern_err update on the edge after the digit-7 capture.
- frame_err asserts on the edge after the offending capture or timeout.
- Reset mid-frame: state returns to HUNT, partial word is discarded, all outputs return to 0, settle counter is cleared. The first capture after reset needs a full SETTLE_CYCLES.
- Simultaneous timeout expiry and capture: the capture wins and the timeout counter reloads.

## Configuration
- SEG_SCAN_HEX_EN defined: patterns A..F decode to 10..15 without error.
- SEG_SCAN_HEX_EN undefined: only 0..9 are legal (BCD counter displays). A..F patterns decode to 0 and set pattern_err.

## Structure
- Shared package seg_pkg holds:
  - The 16 active-low segment pattern constants.
  - The SEG_BLANK (1111111) and COM_NONE (11111111) constants.
  - The FSM state enum {HUNT, ASSEMBLE}.
- Sub-module seg7_to_nibble: combinational pattern in, {nibble, legal} out. It is shared with future display checkers.
- Top level contains the input register, settle counter, one-hot check and index encode, timeout counter, FSM and word assembly.

## Test plan
All scenarios use bench parameters SETTLE_CYCLES=4 and TIMEOUT_CYCLES=64.
- Digits 0..7 show 8,7,6,5,4,3,2,1, each held 10 cycles -> single value_valid, value=0x12345678, pattern_err=0, no frame_err.
- Scan starts at digit 3, then two full frames of 0x00000099 -> first partial is ignored, two valid pulses, value=0x00000099, no frame_err.
- Sequence 0,1,2,3,5 -> frame_err pulse one edge after digit-5 capture, no value_valid, value unchanged; next full frame recovers.
- Digit-2 pattern held 3 cycles between settled patterns, then the real pattern for 10 -> ghost not captured, assembled value correct.
- Digit 2 driven 1111111 -> value_valid with pattern_err=1, value[11:8]=0. Digit 2 driven 0001000 -> A and no error with SEG_SCAN_HEX_EN; 0 and pattern_err=1 without it.
- Halt after digit 4 for 70 cycles -> frame_err pulse, HUNT. Assert reset mid-frame -> all outputs 0, and the following full frame decodes correctly.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment bus: active-low {G..A} digit
// patterns, idle-bus values and the scan decoder FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [7:0] COM_NONE  = 8'b11111111;

  typedef enum logic [0:0] {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } state_e;

  // True when exactly one active-low common is driven.
  function automatic logic com_is_onehot(input logic [7:0] com_n);
    logic [7:0] sel;
    sel = ~com_n;
    return (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational seven-segment pattern to nibble decoder; unknown patterns give 0 with legal low.
// Letters A..F are legal only when SEG_SCAN_HEX_EN is defined.
module seg7_to_nibble
  import seg_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] nibble_o,
  output logic       legal_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b1;
    case (seg_n_i)
      SEG_0: nibble_o = 4'h0;
      SEG_1: nibble_o = 4'h1;
      SEG_2: nibble_o = 4'h2;
      SEG_3: nibble_o = 4'h3;
      SEG_4: nibble_o = 4'h4;
      SEG_5: nibble_o = 4'h5;
      SEG_6: nibble_o = 4'h6;
      SEG_7: nibble_o = 4'h7;
      SEG_8: nibble_o = 4'h8;
      SEG_9: nibble_o = 4'h9;
`ifdef SEG_SCAN_HEX_EN
      SEG_A: nibble_o = 4'hA;
      SEG_B: nibble_o = 4'hB;
      SEG_C: nibble_o = 4'hC;
      SEG_D: nibble_o = 4'hD;
      SEG_E: nibble_o = 4'hE;
      SEG_F: nibble_o = 4'hF;
`endif
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for the scanned 8-digit seven-segment bus: settles, decodes and reassembles
// each full scan into a 32-bit word. Define SEG_SCAN_HEX_EN to accept A..F digits.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_n,
  input  logic [7:0]  com_n,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        pattern_err,
  output logic        frame_err
);

  localparam int unsigned     TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0]     SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [6:0]       seg_q;
  logic [7:0]       com_q;
  logic [15:0]      settle_q, settle_d;
  logic             cap_vld_q;
  logic [2:0]       cap_idx_q;
  logic [3:0]       cap_nib_q;
  logic             cap_legal_q;
  logic [2:0]       com_idx;
  logic [3:0]       dec_nib;
  logic             dec_legal;

  state_e           state_q, state_d;
  logic [2:0]       expect_q, expect_d;
  logic [31:0]      word_q, word_d, word_ins;
  logic             perr_q, perr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      value_q, value_d;
  logic             value_valid_q, value_valid_d;
  logic             pattern_err_q, pattern_err_d;
  logic             frame_err_q, frame_err_d;

  seg7_to_nibble u_dec (
    .seg_n_i  (seg_q),
    .nibble_o (dec_nib),
    .legal_o  (dec_legal)
  );

  always_comb begin
    com_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!com_q[i]) com_idx = 3'(i);
    end
  end

  // The count tracks how long the current registered sample has been stable.
  always_comb begin
    if ({seg_n, com_n} != {seg_q, com_q}) begin
      settle_d = 16'd0;
    end else if (settle_q == 16'hFFFF) begin
      settle_d = settle_q;
    end else begin
      settle_d = settle_q + 16'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    expect_d      = expect_q;
    word_d        = word_q;
    perr_d        = perr_q;
    tmo_d         = tmo_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    pattern_err_d = 1'b0;
    frame_err_d   = 1'b0;
    word_ins      = word_q;
    word_ins[{cap_idx_q, 2'b00} +: 4] = cap_nib_q;

    case (state_q)
      HUNT: begin
        if (cap_vld_q && cap_idx_q == 3'd0) begin
          state_d  = ASSEMBLE;
          expect_d = 3'd1;
          word_d   = {28'd0, cap_nib_q};
          perr_d   = ~cap_legal_q;
          tmo_d    = '0;
        end
      end
      ASSEMBLE: begin
        if (cap_vld_q) begin
          tmo_d = '0;
          if (cap_idx_q == expect_q) begin
            word_d = word_ins;
            perr_d = perr_q | ~cap_legal_q;
            if (expect_q == 3'd7) begin
              value_d       = word_ins;
              value_valid_d = 1'b1;
              pattern_err_d = perr_q | ~cap_legal_q;
              state_d       = HUNT;
            end else begin
              expect_d = expect_q + 3'd1;
            end
          end else begin
            frame_err_d = 1'b1;
            if (cap_idx_q == 3'd0) begin
              expect_d = 3'd1;
              word_d   = {28'd0, cap_nib_q};
              perr_d   = ~cap_legal_q;
            end else begin
              state_d = HUNT;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          state_d     = HUNT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q         <= SEG_BLANK;
      com_q         <= COM_NONE;
      settle_q      <= 16'd0;
      cap_vld_q     <= 1'b0;
      cap_idx_q     <= 3'd0;
      cap_nib_q     <= 4'h0;
      cap_legal_q   <= 1'b0;
      state_q       <= HUNT;
      expect_q      <= 3'd0;
      word_q        <= 32'd0;
      perr_q        <= 1'b0;
      tmo_q         <= '0;
      value_q       <= 32'd0;
      value_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      seg_q         <= seg_n;
      com_q         <= com_n;
      settle_q      <= settle_d;
      // Fires once per stable stretch, on the sample that has been seen SETTLE_CYCLES times.
      cap_vld_q     <= (settle_q == SETTLE_LAST) && com_is_onehot(com_q);
      cap_idx_q     <= com_idx;
      cap_nib_q     <= dec_nib;
      cap_legal_q   <= dec_legal;
      state_q       <= state_d;
      expect_q      <= expect_d;
      word_q        <= word_d;
      perr_q        <= perr_d;
      tmo_q         <= tmo_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      pattern_err_q <= pattern_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign pattern_err = pattern_err_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed plus randomized scan sequences for seg_scan_decoder, scored against a
// digit-level model of the frame assembly rules.
module tb_seg_scan_decoder;

  localparam int S = 4;
  localparam int T = 64;
`ifdef SEG_SCAN_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [7:0]  com_n;
  logic [31:0] value;
  logic        value_valid;
  logic        pattern_err;
  logic        frame_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .com_n       (com_n),
    .value       (value),
    .value_valid (value_valid),
    .pattern_err (pattern_err),
    .frame_err   (frame_err)
  );

  logic [6:0]  pat [16];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          step_cyc = 0;
  int          first_vld_cyc = -1;
  int          last_ferr_cyc = -1;

  logic [31:0] obs_val [$];
  bit          obs_pe  [$];
  int          obs_ferr = 0;

  logic [31:0] exp_val [$];
  bit          exp_pe  [$];
  int          exp_ferr = 0;
  logic [31:0] exp_value = 32'd0;

  bit          m_asm = 1'b0;
  int          m_expect = 0;
  logic [31:0] m_word = 32'd0;
  bit          m_perr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (value_valid === 1'b1) begin
      obs_val.push_back(value);
      obs_pe.push_back(pattern_err);
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
    end
    if (frame_err === 1'b1) begin
      obs_ferr++;
      last_ferr_cyc = cyc;
    end
  endtask

  function automatic void model_start(logic [3:0] nib, bit legal);
    m_asm    = 1'b1;
    m_expect = 1;
    m_word   = {28'd0, nib};
    m_perr   = !legal;
  endfunction

  // One settled, selected digit seen by the receiver.
  function automatic void model_capture(int idx, logic [6:0] p);
    int         j = -1;
    bit         legal;
    logic [3:0] nib;
    for (int i = 0; i < 16; i++) if (pat[i] == p) j = i;
    legal = (j >= 0) && (HEX || j < 10);
    nib   = legal ? 4'(j) : 4'h0;
    if (!m_asm) begin
      if (idx == 0) model_start(nib, legal);
    end else if (idx == m_expect) begin
      m_word[4*idx +: 4] = nib;
      m_perr = m_perr | !legal;
      if (idx == 7) begin
        exp_val.push_back(m_word);
        exp_pe.push_back(m_perr);
        exp_value = m_word;
        m_asm = 1'b0;
      end else begin
        m_expect++;
      end
    end else begin
      exp_ferr++;
      if (idx == 0) model_start(nib, legal);
      else m_asm = 1'b0;
    end
  endfunction

  // idx < 0 drives an unselected (blank) bus.
  task automatic step(input int idx, input logic [6:0] p, input int hold);
    seg_n    = p;
    com_n    = (idx < 0) ? 8'hFF : ~(8'd1 << idx);
    step_cyc = cyc;
    repeat (hold) tick();
    if (idx >= 0 && hold >= S) model_capture(idx, p);
  endtask

  task automatic frame(input logic [31:0] w, input int ovr_idx, input logic [6:0] ovr_pat,
                       input int hold);
    for (int d = 0; d < 8; d++)
      step(d, (d == ovr_idx) ? ovr_pat : pat[w[4*d +: 4]], hold);
  endtask

  task automatic checkpoint(input string tag);
    int n;
    step(-1, 7'h7F, 8);
    check({tag, ".nvalid"}, 32'(obs_val.size()), 32'(exp_val.size()));
    n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".value"}, obs_val[i], exp_val[i]);
      check({tag, ".perr"}, 32'(obs_pe[i]), 32'(exp_pe[i]));
    end
    check({tag, ".nferr"}, 32'(obs_ferr), 32'(exp_ferr));
    check({tag, ".value_out"}, value, exp_value);
    obs_val.delete(); obs_pe.delete(); exp_val.delete(); exp_pe.delete();
    obs_ferr = 0; exp_ferr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    seg_n = 7'h7F;
    com_n = 8'hFF;
    tick();
    tick();
    check("rst.value", value, 32'd0);
    check("rst.value_valid", 32'(value_valid), 32'd0);
    check("rst.pattern_err", 32'(pattern_err), 32'd0);
    check("rst.frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    m_asm = 1'b0;
    exp_value = 32'd0;
    obs_val.delete(); obs_pe.delete(); exp_val.delete(); exp_pe.delete();
    obs_ferr = 0; exp_ferr = 0;
  endtask

  initial begin
    logic [31:0] w;
    int          d7_start;
    pat[0]  = 7'b1000000; pat[1]  = 7'b1111001; pat[2]  = 7'b0100100; pat[3]  = 7'b0110000;
    pat[4]  = 7'b0011001; pat[5]  = 7'b0010010; pat[6]  = 7'b0000010; pat[7]  = 7'b1111000;
    pat[8]  = 7'b0000000; pat[9]  = 7'b0010000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
    pat[12] = 7'b1000110; pat[13] = 7'b0100001; pat[14] = 7'b0000110; pat[15] = 7'b0001110;

    do_reset();

    // Single clean frame, with latency from digit 7 to value_valid.
    first_vld_cyc = -1;
    for (int d = 0; d < 7; d++) step(d, pat[8 - d], 10);
    d7_start = cyc;
    step(7, pat[1], 10);
    check("basic.latency", 32'(first_vld_cyc - d7_start), 32'(S + 2));
    checkpoint("basic");
    check("basic.const", value, 32'h12345678);

    // Scan entered mid-frame, then two back-to-back frames.
    for (int d = 3; d < 8; d++) step(d, pat[d], 10);
    frame(32'h00000099, -1, 7'h00, 10);
    frame(32'h00000099, -1, 7'h00, 10);
    checkpoint("midstart");
    check("midstart.const", value, 32'h00000099);

    // Out-of-order digit, then recovery.
    for (int d = 0; d < 4; d++) step(d, pat[d + 1], 10);
    step(5, pat[6], 10);
    check("order.ferr_latency", 32'(last_ferr_cyc - step_cyc), 32'(S + 2));
    check("order.value_kept", value, 32'h00000099);
    frame(32'h87654321, -1, 7'h00, 10);
    checkpoint("order");

    // Short ghost pattern on digit 2 before its real pattern.
    step(0, pat[4], 10);
    step(1, pat[3], 10);
    step(2, pat[8], S - 1);
    step(2, pat[2], 10);
    for (int d = 3; d < 8; d++) step(d, pat[d], 10);
    checkpoint("ghost");
    check("ghost.const", value, 32'h76543234);

    // Undecodable and letter patterns on digit 2.
    frame(32'h11111111, 2, 7'b1111111, 10);
    checkpoint("blankdig");
    check("blankdig.nib", 32'(value[11:8]), 32'd0);
    frame(32'h22222222, 2, 7'b0001000, 10);
    checkpoint("letterA");
    check("letterA.nib", 32'(value[11:8]), HEX ? 32'hA : 32'h0);

    // Stall mid-frame long enough to time out.
    for (int d = 0; d < 5; d++) step(d, pat[d], 10);
    step(-1, 7'h7F, T + 6);
    exp_ferr++;
    m_asm = 1'b0;
    checkpoint("timeout");
    frame(32'h31415926, -1, 7'h00, 10);
    checkpoint("timeout_recover");

    // Reset mid-frame, then a clean frame.
    for (int d = 0; d < 4; d++) step(d, pat[d + 2], 10);
    do_reset();
    frame(32'h90817263, -1, 7'h00, 10);
    checkpoint("reset_recover");

    // Randomized frames with occasional short ghosts.
    for (int f = 0; f < 8; f++) begin
      for (int d = 0; d < 8; d++) w[4*d +: 4] = 4'(HEX ? $urandom_range(0, 15) : $urandom_range(0, 9));
      for (int d = 0; d < 8; d++) begin
        if ($urandom_range(0, 3) == 0)
          step(int'($urandom_range(0, 7)), pat[$urandom_range(0, 15)], int'($urandom_range(1, S - 1)));
        step(d, pat[w[4*d +: 4]], int'($urandom_range(S, S + 6)));
      end
    end
    checkpoint("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
